// File: rtl/aidc_lite_pkg.sv
// Shared AHB2 encodings and the read-DMA state type for the AIDC-Lite front end.
package aidc_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam int BURST_BEATS = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } rd_dma_state_t;

endpackage

// File: rtl/aidc_lite_sync_fifo.sv
// Single-clock word FIFO; a push into a full FIFO is taken only together with a pop.
module aidc_lite_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push_s, do_pop_s;

  assign empty_o   = (count_q == CW'(0));
  assign full_o    = (count_q == CW'(DEPTH));
  assign do_push_s = push_i && (!full_o || pop_i);
  assign do_pop_s  = pop_i && !empty_o;
  assign dout_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q] <= din_i;
  end

  aidc_lite_sync_fifo_chk u_chk (
    .clk    (clk),
    .rst    (rst),
    .push_i (push_i),
    .pop_i  (pop_i),
    .full_i (full_o)
  );

endmodule

// Credit flow control upstream must never offer a word the FIFO cannot take.
module aidc_lite_sync_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push_i,
  input logic pop_i,
  input logic full_i
);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_i && full_i && !pop_i));
endmodule

// File: rtl/aidc_lite_ahb_rd_dma.sv
// AHB2 read-DMA master: fetches whole 16-byte INCR4 bursts and streams the words out of a FIFO.
module aidc_lite_ahb_rd_dma
  import aidc_lite_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [31:0]       cfg_len,
  input  logic              cfg_start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              hbusreq,
  input  logic              hgrant,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic              hwrite,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic [1:0]        hresp,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(FIFO_DEPTH - BURST_BEATS);

  rd_dma_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, haddr_q, haddr_d;
  logic [29:0]       rem_q, rem_d;
  logic [2:0]        bcnt_q, bcnt_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [2:0]        hburst_q, hburst_d;
  logic [CW-1:0]     resv_q, resv_d;
  logic              resume_q, resume_d, dphase_q, dphase_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [CW-1:0]     fifo_count_s;
  logic [CW:0]       used_s;
  logic              fifo_full_s, fifo_empty_s;
  logic              push_s, pop_s, bus_err_s, credit_ok_s, hbusreq_s;
  logic              unused_s;

  assign bus_err_s   = dphase_q && (hresp != HRESP_OKAY);
  assign push_s      = dphase_q && hready && (hresp == HRESP_OKAY);
  assign pop_s       = !fifo_empty_s && m_ready;
  assign used_s      = {1'b0, fifo_count_s} + {1'b0, resv_q};
  assign credit_ok_s = (used_s <= CREDIT_MAX);
  assign unused_s    = ^{cfg_src[3:0], cfg_len[3:0], fifo_full_s};

  always_comb begin
    case (state_q)
      ST_ARB:  hbusreq_s = resume_q || credit_ok_s;
      ST_ADDR: hbusreq_s = (bcnt_q != 3'd1);
      default: hbusreq_s = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    haddr_d  = haddr_q;
    rem_d    = rem_q;
    bcnt_d   = bcnt_q;
    htrans_d = htrans_q;
    hburst_d = hburst_q;
    resume_d = resume_q;
    resv_d   = resv_q - CW'(push_s);
    dphase_d = hready ? (htrans_q != HTRANS_IDLE) : dphase_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          addr_d   = {cfg_src[ADDR_W-1:4], 4'b0000};
          rem_d    = {cfg_len[31:4], 2'b00};
          busy_d   = 1'b1;
          err_d    = 1'b0;
          resume_d = 1'b0;
          state_d  = (cfg_len[31:4] == 28'd0) ? ST_FIN : ST_ARB;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARB: begin
        // A resumed burst already holds its FIFO credit from when it first started.
        if (hbusreq_s && hgrant && hready) begin
          state_d  = ST_ADDR;
          htrans_d = HTRANS_NONSEQ;
          haddr_d  = addr_q;
          hburst_d = resume_q ? HBURST_INCR : HBURST_INCR4;
          if (!resume_q) begin
            bcnt_d = 3'd4;
            resv_d = resv_q - CW'(push_s) + CW'(BURST_BEATS);
          end else begin
            bcnt_d = bcnt_q;
          end
        end else begin
          state_d = ST_ARB;
        end
      end
      ST_ADDR: begin
        if (hready) begin
          addr_d = addr_q + ADDR_W'(4);
          rem_d  = rem_q - 30'd1;
          bcnt_d = bcnt_q - 3'd1;
          if (bcnt_q == 3'd1) begin
            htrans_d = HTRANS_IDLE;
            resume_d = 1'b0;
            state_d  = (rem_q == 30'd1) ? ST_DRAIN : ST_ARB;
          end else if (hgrant) begin
            htrans_d = HTRANS_SEQ;
            haddr_d  = addr_q + ADDR_W'(4);
          end else begin
            htrans_d = HTRANS_IDLE;
            resume_d = 1'b1;
            state_d  = ST_ARB;
          end
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DRAIN: begin
        if (dphase_q && hready) state_d = ST_FIN;
        else                    state_d = ST_DRAIN;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // An error response abandons everything still queued for this transfer.
    if (bus_err_s) begin
      htrans_d = HTRANS_IDLE;
      dphase_d = 1'b0;
      rem_d    = 30'd0;
      bcnt_d   = 3'd0;
      resv_d   = CW'(0);
      resume_d = 1'b0;
      err_d    = 1'b1;
      state_d  = ST_FIN;
    end else begin
      err_d = err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      haddr_q  <= '0;
      rem_q    <= 30'd0;
      bcnt_q   <= 3'd0;
      htrans_q <= HTRANS_IDLE;
      hburst_q <= HBURST_INCR4;
      resv_q   <= CW'(0);
      resume_q <= 1'b0;
      dphase_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      haddr_q  <= haddr_d;
      rem_q    <= rem_d;
      bcnt_q   <= bcnt_d;
      htrans_q <= htrans_d;
      hburst_q <= hburst_d;
      resv_q   <= resv_d;
      resume_q <= resume_d;
      dphase_q <= dphase_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  aidc_lite_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .din_i   (hrdata),
    .pop_i   (pop_s),
    .dout_o  (m_data),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // The slave sees IDLE already in the first cycle of a two-cycle error response.
  assign htrans  = bus_err_s ? HTRANS_IDLE : htrans_q;
  assign haddr   = haddr_q;
  assign hburst  = hburst_q;
  assign hbusreq = hbusreq_s;
  assign hsize   = HSIZE_WORD;
  assign hprot   = HPROT_DATA;
  assign hwrite  = 1'b0;
  assign hwdata  = {DATA_W{1'b0}};
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign m_valid = !fifo_empty_s;

endmodule

// File: tb/tb_aidc_lite_ahb_rd_dma.sv
// Self-checking bench: AHB memory slave returning each word's own address, directed and random transfers.
module tb_aidc_lite_ahb_rd_dma;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, cfg_start, m_ready;
  logic [31:0] cfg_src, cfg_len;
  logic        busy, done, err, hbusreq, hgrant, hwrite, hready, m_valid;
  logic [31:0] haddr, hwdata, hrdata, m_data;
  logic [1:0]  htrans, hresp;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;

  always #5 clk = ~clk;

  aidc_lite_ahb_rd_dma #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_src(cfg_src), .cfg_len(cfg_len), .cfg_start(cfg_start),
    .busy(busy), .done(done), .err(err), .hbusreq(hbusreq), .hgrant(hgrant),
    .haddr(haddr), .htrans(htrans), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave and arbiter knobs, written only by the stimulus process.
  bit          rnd_ws = 1'b0, rnd_rdy = 1'b0, err_en = 1'b0, revoke_en = 1'b0;
  logic [31:0] err_addr = 32'h0, revoke_addr = 32'h0;

  logic        dp_v = 1'b0;
  logic [31:0] dp_a = 32'h0;
  int          ws = 0, errph = 0, revoke_cnt = 0;
  bit          revoke_fired = 1'b0;
  int          nonseq_cnt = 0, resume_cnt = 0;
  logic [31:0] resume_addr = 32'h0;

  assign hready = !(dp_v && (errph == 1 || ws != 0));
  assign hresp  = (dp_v && errph != 0) ? 2'b01 : 2'b00;
  assign hrdata = dp_a;
  assign hgrant = (revoke_cnt == 0) &&
                  !(revoke_en && !revoke_fired && htrans == 2'b11 && haddr == revoke_addr);

  always @(posedge clk) begin
    if (rst) begin
      dp_v <= 1'b0; errph <= 0; ws <= 0; revoke_cnt <= 0;
    end else begin
      if (revoke_cnt > 0) revoke_cnt <= revoke_cnt - 1;
      if (hready) begin
        if (htrans[1]) begin
          dp_v <= 1'b1;
          dp_a <= haddr;
          if (err_en && haddr == err_addr) begin
            errph <= 1; ws <= 0;
          end else begin
            errph <= 0; ws <= rnd_ws ? int'($urandom_range(0, 2)) : 0;
          end
          if (htrans == 2'b10) begin
            nonseq_cnt <= nonseq_cnt + 1;
            if (hburst == 3'b001) begin
              resume_cnt <= resume_cnt + 1; resume_addr <= haddr;
            end
          end
          if (revoke_en && !revoke_fired && htrans == 2'b11 && haddr == revoke_addr) begin
            revoke_cnt <= 3; revoke_fired <= 1'b1;
          end
        end else begin
          dp_v <= 1'b0; errph <= 0;
        end
      end else begin
        if (errph == 1) errph <= 2;
        else if (ws > 0) ws <= ws - 1;
      end
    end
  end

  logic [31:0] obs_mem [4096];
  int obs_n = 0, done_cnt = 0, breq_cnt = 0, errcyc_cnt = 0, errbad_cnt = 0;

  always @(negedge clk) begin
    if (m_valid && m_ready && obs_n < 4096) begin
      obs_mem[obs_n] = m_data;
      obs_n++;
    end
    if (done) done_cnt++;
    if (hbusreq) breq_cnt++;
    if (hresp == 2'b01 && !hready) begin
      errcyc_cnt++;
      if (htrans != 2'b00) errbad_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] src, input logic [31:0] len);
    cfg_src = src; cfg_len = len; cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input int d0);
    for (int i = 0; i < budget && done_cnt == d0; i++) begin
      if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 200 && m_valid; i++) tick(1);
    tick(2);
    check_val({tag, "_done_once"}, done_cnt - d0, 1);
  endtask

  task automatic check_stream(input string tag, input logic [31:0] base, input int n, input int o0);
    check_val({tag, "_words"}, obs_n - o0, n);
    for (int i = 0; i < n && o0 + i < obs_n; i++)
      check_val({tag, "_data"}, obs_mem[o0 + i], base + 32'(4 * i));
  endtask

  initial begin
    int d0, o0, b0, n0, r0, e0, x0;
    logic [31:0] src, len;
    rst = 1'b1; cfg_start = 1'b0; cfg_src = 32'h0; cfg_len = 32'h0; m_ready = 1'b1;
    tick(3);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_hbusreq", 32'(hbusreq), 32'd0);
    check_val("rst_htrans", 32'(htrans), 32'd0);
    check_val("rst_haddr", haddr, 32'h0);
    check_val("rst_m_valid", 32'(m_valid), 32'd0);
    check_val("const_hsize", 32'(hsize), 32'd2);
    check_val("const_hprot", 32'(hprot), 32'd3);
    check_val("const_hwrite", 32'(hwrite), 32'd0);
    check_val("const_hwdata", hwdata, 32'h0);
    rst = 1'b0;
    tick(2);

    // 256 bytes from 0 with a zero-wait slave
    d0 = done_cnt; o0 = obs_n; n0 = nonseq_cnt;
    do_start(32'h0, 32'h100);
    check_val("t1_hbusreq_lat", 32'(hbusreq), 32'd1);
    check_val("t1_busy", 32'(busy), 32'd1);
    wait_done("t1", 1000, d0);
    check_stream("t1", 32'h0, 64, o0);
    check_val("t1_bursts", nonseq_cnt - n0, 16);
    check_val("t1_err", 32'(err), 32'd0);

    // zero length: done two cycles after start, no bus use
    d0 = done_cnt; o0 = obs_n; b0 = breq_cnt;
    do_start(32'h40, 32'h0);
    check_val("t2_done_early", 32'(done), 32'd0);
    tick(1);
    check_val("t2_done_pulse", 32'(done), 32'd1);
    check_val("t2_busy", 32'(busy), 32'd0);
    tick(3);
    check_val("t2_hbusreq", breq_cnt - b0, 0);
    check_val("t2_words", obs_n - o0, 0);
    check_val("t2_done_once", done_cnt - d0, 1);

    // consumer stalled: only two bursts fit the FIFO
    d0 = done_cnt; o0 = obs_n; n0 = nonseq_cnt;
    m_ready = 1'b0;
    do_start(32'h0, 32'h40);
    tick(60);
    check_val("t3_bursts", nonseq_cnt - n0, 2);
    b0 = breq_cnt;
    tick(20);
    check_val("t3_hbusreq_quiet", breq_cnt - b0, 0);
    check_val("t3_m_valid", 32'(m_valid), 32'd1);
    check_val("t3_busy", 32'(busy), 32'd1);
    m_ready = 1'b1;
    wait_done("t3", 500, d0);
    check_stream("t3", 32'h0, 16, o0);

    // grant revoked after the 2nd beat of the third burst
    d0 = done_cnt; o0 = obs_n; n0 = nonseq_cnt; r0 = resume_cnt;
    revoke_addr = 32'h124; revoke_en = 1'b1;
    do_start(32'h100, 32'h40);
    wait_done("t4", 500, d0);
    revoke_en = 1'b0;
    check_val("t4_resumes", resume_cnt - r0, 1);
    check_val("t4_resume_addr", resume_addr, 32'h128);
    check_val("t4_nonseq", nonseq_cnt - n0, 5);
    check_stream("t4", 32'h100, 16, o0);

    // ERROR response on the beat at 0x20
    d0 = done_cnt; o0 = obs_n; e0 = errcyc_cnt; x0 = errbad_cnt;
    err_addr = 32'h20; err_en = 1'b1;
    do_start(32'h0, 32'h40);
    wait_done("t5", 500, d0);
    err_en = 1'b0;
    check_val("t5_err", 32'(err), 32'd1);
    check_val("t5_err_cycles", errcyc_cnt - e0, 1);
    check_val("t5_htrans_idle", errbad_cnt - x0, 0);
    check_val("t5_busy", 32'(busy), 32'd0);
    check_stream("t5", 32'h0, 8, o0);

    // reset in the middle of a burst, then a clean transfer
    do_start(32'h0, 32'h100);
    check_val("t6_err_cleared", 32'(err), 32'd0);
    tick(9);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_val("t6_htrans", 32'(htrans), 32'd0);
    check_val("t6_hbusreq", 32'(hbusreq), 32'd0);
    check_val("t6_busy", 32'(busy), 32'd0);
    check_val("t6_m_valid", 32'(m_valid), 32'd0);
    tick(2);
    d0 = done_cnt; o0 = obs_n;
    do_start(32'h200, 32'h40);
    wait_done("t6", 500, d0);
    check_stream("t6", 32'h200, 16, o0);
    check_val("t6_err", 32'(err), 32'd0);

    // random sources/lengths, wait states and consumer stalls
    rnd_ws = 1'b1; rnd_rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      src = $urandom;
      if (k < 3) src = 32'hFFFF_FF00 | (src & 32'h0000_00FF);
      len = ($urandom_range(0, 12) << 4) | $urandom_range(0, 15);
      d0 = done_cnt; o0 = obs_n;
      do_start(src, len);
      wait_done("rnd", 3000, d0);
      check_stream("rnd", src & 32'hFFFF_FFF0, int'(len >> 4) * 4, o0);
      check_val("rnd_err", 32'(err), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
